// File: rtl/ram_vector_adder.sv
// Element-wise C[i] = A[i] + B[i] sequencer driving a 1W/2R RAM (async reads, sync write).
// One element per cycle; optional signed saturation; sticky overflow per command.
module ram_vector_adder #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 6,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_addr1,
  output logic [ADDR_W-1:0] ram_addr2,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do1,
  input  logic [DATA_W-1:0] ram_do2
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   len_clamp;
  logic [DATA_W:0]   sum;
  logic              elem_ovf;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] di_hold;

  assign len_clamp = (len > DEPTH) ? DEPTH : len;
  assign sum       = {ram_do1[DATA_W-1], ram_do1} + {ram_do2[DATA_W-1], ram_do2};
  assign elem_ovf  = sum[DATA_W] ^ sum[DATA_W-1];

  always_comb begin
    result = sum[DATA_W-1:0];
    if (SATURATE && elem_ovf)
      result = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  // Write data is live only in RUN; otherwise replay the last written word
  // so the port holds steady and reads zero out of reset.
  assign ram_di = (state == RUN) ? result : di_hold;

  assign busy   = (state == RUN);
  assign ram_we = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      len_r     <= '0;
      idx       <= '0;
      overflow  <= 1'b0;
      di_hold   <= '0;
      ram_addr1 <= '0;
      ram_addr2 <= '0;
      ram_waddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ram_addr1 <= base_a;
            ram_addr2 <= base_b;
            ram_waddr <= base_c;
            len_r     <= len_clamp;
            idx       <= '0;
            overflow  <= 1'b0;
            state     <= (len_clamp == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          di_hold <= result;
          if (elem_ovf)
            overflow <= 1'b1;
          if (idx == len_r - 1'b1) begin
            state <= DONE;
          end else begin
            idx       <= idx + 1'b1;
            ram_addr1 <= ram_addr1 + 1'b1;
            ram_addr2 <= ram_addr2 + 1'b1;
            ram_waddr <= ram_waddr + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_vector_adder.sv
// Directed bench for ram_vector_adder: saturating and wrapping instances share
// one command stream, each attached to its own behavioural 64x16 RAM.
module tb_ram_vector_adder;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [5:0]  base_a, base_b, base_c;
  logic [6:0]  len;

  logic        busy_s, done_s, ovf_s, we_s;
  logic [5:0]  waddr_s, addr1_s, addr2_s;
  logic [15:0] di_s, do1_s, do2_s;
  logic        busy_w, done_w, ovf_w, we_w;
  logic [5:0]  waddr_w, addr1_w, addr2_w;
  logic [15:0] di_w, do1_w, do2_w;

  logic [15:0] mem_s [64];
  logic [15:0] mem_w [64];
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [15:0] pre_data;

  int compared   = 0;
  int mismatched = 0;
  int we_cnt_s   = 0;
  int we_cnt_w   = 0;

  ram_vector_adder #(.DATA_W(16), .ADDR_W(6), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .base_a(base_a), .base_b(base_b), .base_c(base_c), .len(len),
    .busy(busy_s), .done(done_s), .overflow(ovf_s),
    .ram_we(we_s), .ram_waddr(waddr_s), .ram_addr1(addr1_s), .ram_addr2(addr2_s),
    .ram_di(di_s), .ram_do1(do1_s), .ram_do2(do2_s)
  );

  ram_vector_adder #(.DATA_W(16), .ADDR_W(6), .SATURATE(1'b0)) u_wrap (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .base_a(base_a), .base_b(base_b), .base_c(base_c), .len(len),
    .busy(busy_w), .done(done_w), .overflow(ovf_w),
    .ram_we(we_w), .ram_waddr(waddr_w), .ram_addr1(addr1_w), .ram_addr2(addr2_w),
    .ram_di(di_w), .ram_do1(do1_w), .ram_do2(do2_w)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pre_we) begin
      mem_s[pre_addr] <= pre_data;
      mem_w[pre_addr] <= pre_data;
    end else begin
      if (we_s) mem_s[waddr_s] <= di_s;
      if (we_w) mem_w[waddr_w] <= di_w;
    end
    if (we_s) we_cnt_s <= we_cnt_s + 1;
    if (we_w) we_cnt_w <= we_cnt_w + 1;
  end

  assign do1_s = mem_s[addr1_s];
  assign do2_s = mem_s[addr2_s];
  assign do1_w = mem_w[addr1_w];
  assign do2_w = mem_w[addr2_w];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkm(input string tag, input logic [5:0] a,
                      input logic [15:0] exp_s, input logic [15:0] exp_w);
    chk({tag, "_sat"},  {16'h0, mem_s[a]}, {16'h0, exp_s});
    chk({tag, "_wrap"}, {16'h0, mem_w[a]}, {16'h0, exp_w});
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      chk("busy_done_excl", {31'h0, busy_s & done_s}, 32'h0);
      chk("we_only_busy",   {31'h0, we_s & ~busy_s},  32'h0);
    end
  end

  task automatic ld(input logic [5:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge CLK); #1;
    pre_we = 1'b0;
  endtask

  // Issue one command; n is the expected number of RUN cycles. With poke set,
  // start is held high (with scrambled bases) through RUN and DONE.
  task automatic cmd(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                     input logic [6:0] l, input int n, input bit poke);
    int w0s, w0w;
    base_a = a; base_b = b; base_c = c; len = l; start = 1'b1;
    w0s = we_cnt_s; w0w = we_cnt_w;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [5:0] ea, eb, ec;
      ea = a + 6'(i); eb = b + 6'(i); ec = c + 6'(i);
      chk("busy_run",   {31'h0, busy_s}, 32'h1);
      chk("busy_run_w", {31'h0, busy_w}, 32'h1);
      chk("done_run",   {31'h0, done_s}, 32'h0);
      chk("we_run",     {31'h0, we_s},   32'h1);
      chk("addr1",      {26'h0, addr1_s}, {26'h0, ea});
      chk("addr2",      {26'h0, addr2_s}, {26'h0, eb});
      chk("waddr",      {26'h0, waddr_s}, {26'h0, ec});
      if (poke) begin
        start = 1'b1; base_a = ~a; base_b = ~b; base_c = ~c; len = 7'd5;
      end
      @(posedge CLK); #1;
    end
    chk("done_pulse",   {31'h0, done_s}, 32'h1);
    chk("done_pulse_w", {31'h0, done_w}, 32'h1);
    chk("busy_done",    {31'h0, busy_s}, 32'h0);
    chk("we_done",      {31'h0, we_s},   32'h0);
    @(posedge CLK); #1;
    start = 1'b0;
    chk("done_clear", {31'h0, done_s}, 32'h0);
    chk("idle_busy",  {31'h0, busy_s}, 32'h0);
    chk("we_count",   we_cnt_s - w0s, n);
    chk("we_count_w", we_cnt_w - w0w, n);
    if (poke) begin
      @(posedge CLK); #1;
      chk("no_second_busy", {31'h0, busy_s}, 32'h0);
      chk("no_second_done", {31'h0, done_s}, 32'h0);
    end
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; base_a = '0; base_b = '0; base_c = '0; len = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    #12;
    chk("rst_busy",  {31'h0, busy_s}, 32'h0);
    chk("rst_done",  {31'h0, done_s}, 32'h0);
    chk("rst_ovf",   {31'h0, ovf_s},  32'h0);
    chk("rst_we",    {31'h0, we_s},   32'h0);
    chk("rst_waddr", {26'h0, waddr_s}, 32'h0);
    chk("rst_addr1", {26'h0, addr1_s}, 32'h0);
    chk("rst_addr2", {26'h0, addr2_s}, 32'h0);
    chk("rst_di",    {16'h0, di_s},    32'h0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // basic
    ld(6'd0, 16'd1);  ld(6'd1, 16'd2);  ld(6'd2, 16'd3);  ld(6'd3, 16'd4);
    ld(6'd16, 16'd10); ld(6'd17, 16'd20); ld(6'd18, 16'd30); ld(6'd19, 16'd40);
    cmd(6'd0, 6'd16, 6'd32, 7'd4, 4, 1'b0);
    chkm("basic32", 6'd32, 16'd11, 16'd11);
    chkm("basic33", 6'd33, 16'd22, 16'd22);
    chkm("basic34", 6'd34, 16'd33, 16'd33);
    chkm("basic35", 6'd35, 16'd44, 16'd44);
    chk("basic_ovf", {31'h0, ovf_s}, 32'h0);

    // positive and negative overflow, saturate vs wrap
    ld(6'd0, 16'h7FFF); ld(6'd1, 16'h8000); ld(6'd8, 16'h0001); ld(6'd9, 16'hFFFF);
    cmd(6'd0, 6'd8, 6'd50, 7'd2, 2, 1'b0);
    chkm("sat_pos", 6'd50, 16'h7FFF, 16'h8000);
    chkm("sat_neg", 6'd51, 16'h8000, 16'h7FFF);
    repeat (3) @(posedge CLK);
    #1;
    chk("ovf_sticky_s", {31'h0, ovf_s}, 32'h1);
    chk("ovf_sticky_w", {31'h0, ovf_w}, 32'h1);

    // len=0: done in acceptance cycle, no write, overflow cleared
    cmd(6'd0, 6'd8, 6'd50, 7'd0, 0, 1'b0);
    chk("len0_ovf_s", {31'h0, ovf_s}, 32'h0);
    chk("len0_ovf_w", {31'h0, ovf_w}, 32'h0);
    chkm("len0_keep", 6'd50, 16'h7FFF, 16'h8000);

    // address wrap 63->0
    ld(6'd62, 16'd100); ld(6'd63, 16'd200); ld(6'd0, 16'd300); ld(6'd1, 16'd400);
    ld(6'd30, 16'hFFFF); ld(6'd31, 16'd2); ld(6'd32, 16'hFFF6); ld(6'd33, 16'd5);
    cmd(6'd62, 6'd30, 6'd60, 7'd4, 4, 1'b0);
    chkm("wrap60", 6'd60, 16'h0063, 16'h0063);
    chkm("wrap61", 6'd61, 16'h00CA, 16'h00CA);
    chkm("wrap62", 6'd62, 16'h0122, 16'h0122);
    chkm("wrap63", 6'd63, 16'h0195, 16'h0195);
    chkm("wrap_a0", 6'd0, 16'h012C, 16'h012C);
    chk("wrap_ovf", {31'h0, ovf_s}, 32'h0);

    // overlapping result feeds next operand
    ld(6'd0, 16'd1); ld(6'd1, 16'd1); ld(6'd2, 16'd1); ld(6'd3, 16'd1);
    ld(6'd40, 16'd1); ld(6'd41, 16'd1); ld(6'd42, 16'd1); ld(6'd43, 16'd1);
    cmd(6'd0, 6'd40, 6'd1, 7'd3, 3, 1'b0);
    chkm("chain1", 6'd1, 16'd2, 16'd2);
    chkm("chain2", 6'd2, 16'd3, 16'd3);
    chkm("chain3", 6'd3, 16'd4, 16'd4);

    // start held through RUN and DONE is ignored
    cmd(6'd0, 6'd16, 6'd20, 7'd3, 3, 1'b1);
    chkm("poke20", 6'd20, 16'd11, 16'd11);
    chkm("poke21", 6'd21, 16'd22, 16'd22);
    chkm("poke22", 6'd22, 16'd33, 16'd33);

    // reset mid-RUN after two writes
    ld(6'd0, 16'd5); ld(6'd1, 16'd6); ld(6'd16, 16'd7); ld(6'd17, 16'd8);
    ld(6'd48, 16'hAAAA); ld(6'd49, 16'hAAAA); ld(6'd50, 16'hAAAA);
    begin
      int w0;
      w0 = we_cnt_s;
      base_a = 6'd0; base_b = 6'd16; base_c = 6'd48; len = 7'd8; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST_N = 1'b0;
      #1;
      chk("mid_rst_we",    {31'h0, we_s},    32'h0);
      chk("mid_rst_busy",  {31'h0, busy_s},  32'h0);
      chk("mid_rst_done",  {31'h0, done_s},  32'h0);
      chk("mid_rst_waddr", {26'h0, waddr_s}, 32'h0);
      chk("mid_rst_addr1", {26'h0, addr1_s}, 32'h0);
      chk("mid_rst_di",    {16'h0, di_s},    32'h0);
      chk("mid_rst_writes", we_cnt_s - w0, 2);
    end
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chkm("rst48", 6'd48, 16'd12, 16'd12);
    chkm("rst49", 6'd49, 16'd14, 16'd14);
    chkm("rst50", 6'd50, 16'hAAAA, 16'hAAAA);
    cmd(6'd0, 6'd16, 6'd56, 7'd2, 2, 1'b0);
    chkm("post56", 6'd56, 16'd12, 16'd12);
    chkm("post57", 6'd57, 16'd14, 16'd14);

    // full-depth and over-length commands
    cmd(6'd0, 6'd0, 6'd0, 7'd64, 64, 1'b0);
    cmd(6'd5, 6'd9, 6'd3, 7'd100, 64, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
